platform_probe: RTL and testbench
=================================

PLATFORM_PROBE -- requirements
Module: platform_probe

Interface
REQ-001 SHALL have parameter SPR_W, default 16: player sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 16: player sprite height in pixels.
REQ-003 SHALL have parameter PIPE_DLY, default 1: cycles by which platforms_on lags its x,y.
REQ-004 SHALL have port clk, input, 1: pixel clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port video_on, input, 1: active-area flag, aligned with x,y.
REQ-007 SHALL have ports x, y, input, 10 each: current pixel coordinate.
REQ-008 SHALL have port platforms_on, input, 1: platform/wall pixel flag from the floors stage, lagging x,y by PIPE_DLY.
REQ-009 SHALL have ports player_x, player_y, input, 10 each: sprite top-left corner.
REQ-010 SHALL have ports on_ground, wall_left, wall_right, ceiling, output, 1 each: published collision flags.
REQ-011 SHALL have port flags_valid, output, 1: published flags pending.
REQ-012 SHALL have port flags_ack, input, 1: consumer accepts published flags.

Function
REQ-013 SHALL delay x, y, video_on by PIPE_DLY registers so that they align with platforms_on; all probing SHALL use the delayed values (dx, dy, dvo).
REQ-014 SHALL implement states IDLE, SCAN, PUBLISH.
REQ-015 SHALL move IDLE->SCAN when dvo=1 and (dx,dy)=(0,0), latching player_x/player_y as px/py in that cycle; the latched values SHALL be fixed for the rest of the frame.
REQ-016 SHALL clear the four sticky hit registers on the SCAN entry cycle.
REQ-017 SHALL in SCAN, when dvo=1 and platforms_on=1, set ground hit if dy==py+SPR_H and px+2<=dx<=px+SPR_W-3.
REQ-018 SHALL set ceiling hit if dy==py-1 and px+2<=dx<=px+SPR_W-3; disabled when py==0.
REQ-019 SHALL set left hit if dx==px-1 and py+2<=dy<=py+SPR_H-3; disabled when px==0.
REQ-020 SHALL set right hit if dx==px+SPR_W and same dy range; disabled when px+SPR_W>639.
REQ-021 SHALL evaluate all coordinate arithmetic in 11 bits so that no sum or difference wraps.
REQ-022 SHALL move SCAN->PUBLISH on the cycle (dx,dy)=(639,479) with dvo=1, including that pixel's hit.
REQ-023 SHALL in PUBLISH copy the hit registers to the outputs, set flags_valid=1, and return to IDLE, all in one cycle.
REQ-024 SHALL hold outputs and flags_valid until flags_ack=1 is sampled while flags_valid=1, which clears flags_valid the next cycle.
REQ-025 SHALL, when a new PUBLISH coincides with flags_ack, let the new data win and keep flags_valid=1.
REQ-026 SHALL, when PUBLISH occurs with flags_valid=1 and no ack, overwrite the flags.
REQ-027 SHALL ignore flags_ack while flags_valid=0.

Reset
REQ-028 SHALL, on reset, set state=IDLE, hit registers=0, outputs=0, flags_valid=0, delay line=0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame; the first publish SHALL follow the next complete frame.

Configuration
REQ-030 SHALL, with CEIL_PROBE_EN defined, implement the ceiling probe per REQ-018.
REQ-031 SHALL, without CEIL_PROBE_EN, tie ceiling to 0, omit its logic, and leave all other behaviour unchanged.

Verification
REQ-032 SHALL cover: player (100,200), platform pixels at y=216, x=102..113 -> on_ground=1, others 0, flags_valid rises 1 cycle after (639,479).
REQ-033 SHALL cover: player (0,300), platform at x=0 column -> wall_left=0 (probe disabled); platform at x=16, y=302 -> wall_right=1.
REQ-034 SHALL cover: platform pixel only at x=101 on the foot row (outside the 2..SPR_W-3 band) -> on_ground=0.
REQ-035 SHALL cover: player_x changed 100->300 mid-frame -> probes use 100 for that frame and 300 the next.
REQ-036 SHALL cover: reset asserted at (320,240) -> no publish that frame; first flags_valid after the next full frame; ack on the publish cycle -> flags_valid stays 1 with new data.
REQ-037 SHALL cover: with and without CEIL_PROBE_EN, platform at y=py-1 -> ceiling=1 and 0 respectively.

Source files
------------

// File: rtl/platform_probe.sv
// Per-frame collision probe around the player sprite: samples floor/wall pixels
// on the sprite's edges and publishes four sticky hit flags. Ceiling probe: CEIL_PROBE_EN.
module platform_probe #(
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int PIPE_DLY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       platforms_on,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       on_ground,
    output logic       wall_left,
    output logic       wall_right,
    output logic       ceiling,
    output logic       flags_valid,
    input  logic       flags_ack
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUBLISH
    } state_t;

    localparam logic [10:0] W11   = 11'(SPR_W);
    localparam logic [10:0] H11   = 11'(SPR_H);
    localparam logic [10:0] X_MAX = 11'd639;
    localparam logic [10:0] Y_MAX = 11'd479;

    state_t state_q, state_d;

    logic [9:0]          x_dly_q [PIPE_DLY];
    logic [9:0]          x_dly_d [PIPE_DLY];
    logic [9:0]          y_dly_q [PIPE_DLY];
    logic [9:0]          y_dly_d [PIPE_DLY];
    logic [PIPE_DLY-1:0] vo_dly_q, vo_dly_d;

    logic [9:0] px_q, px_d;
    logic [9:0] py_q, py_d;

    logic gnd_hit_q, gnd_hit_d;
    logic lft_hit_q, lft_hit_d;
    logic rgt_hit_q, rgt_hit_d;
    logic gnd_out_q, gnd_out_d;
    logic lft_out_q, lft_out_d;
    logic rgt_out_q, rgt_out_d;
    logic fv_q, fv_d;

    logic [10:0] dx, dy, px11, py11;
    logic        dvo;
    logic        frame_start, frame_end;
    logic        pix_hit, in_xband, in_yband;
    logic        gnd_now, lft_now, rgt_now;

    always_comb begin
        x_dly_d[0]  = x;
        y_dly_d[0]  = y;
        vo_dly_d[0] = video_on;
        for (int i = 1; i < PIPE_DLY; i++) begin
            x_dly_d[i]  = x_dly_q[i-1];
            y_dly_d[i]  = y_dly_q[i-1];
            vo_dly_d[i] = vo_dly_q[i-1];
        end
    end

    // All probe arithmetic is 11 bits wide so px-1 / py+SPR_H never wrap.
    assign dx   = {1'b0, x_dly_q[PIPE_DLY-1]};
    assign dy   = {1'b0, y_dly_q[PIPE_DLY-1]};
    assign dvo  = vo_dly_q[PIPE_DLY-1];
    assign px11 = {1'b0, px_q};
    assign py11 = {1'b0, py_q};

    assign frame_start = dvo && (dx == 11'd0) && (dy == 11'd0);
    assign frame_end   = dvo && (dx == X_MAX) && (dy == Y_MAX);

    assign pix_hit  = (state_q == SCAN) && dvo && platforms_on;
    assign in_xband = (dx >= px11 + 11'd2) && (dx <= px11 + W11 - 11'd3);
    assign in_yband = (dy >= py11 + 11'd2) && (dy <= py11 + H11 - 11'd3);

    assign gnd_now = pix_hit && (dy == py11 + H11) && in_xband;
    assign lft_now = pix_hit && (px_q != 10'd0)
                   && (dx == px11 - 11'd1) && in_yband;
    assign rgt_now = pix_hit && (px11 + W11 <= X_MAX)
                   && (dx == px11 + W11) && in_yband;

`ifdef CEIL_PROBE_EN
    logic ceil_hit_q, ceil_hit_d;
    logic ceil_out_q, ceil_out_d;
    logic ceil_now;

    assign ceil_now = pix_hit && (py_q != 10'd0)
                    && (dy == py11 - 11'd1) && in_xband;

    always_comb begin
        ceil_hit_d = ceil_hit_q;
        ceil_out_d = ceil_out_q;
        unique case (state_q)
            IDLE:    if (frame_start) ceil_hit_d = 1'b0;
            SCAN:    ceil_hit_d = ceil_hit_q | ceil_now;
            PUBLISH: ceil_out_d = ceil_hit_q;
            default: ceil_hit_d = ceil_hit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ceil_hit_q <= 1'b0;
            ceil_out_q <= 1'b0;
        end else begin
            ceil_hit_q <= ceil_hit_d;
            ceil_out_q <= ceil_out_d;
        end
    end

    assign ceiling = ceil_out_q;
`else
    assign ceiling = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        gnd_hit_d = gnd_hit_q;
        lft_hit_d = lft_hit_q;
        rgt_hit_d = rgt_hit_q;
        gnd_out_d = gnd_out_q;
        lft_out_d = lft_out_q;
        rgt_out_d = rgt_out_q;
        fv_d      = fv_q;
        if (fv_q && flags_ack) fv_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = SCAN;
                    px_d      = player_x;
                    py_d      = player_y;
                    gnd_hit_d = 1'b0;
                    lft_hit_d = 1'b0;
                    rgt_hit_d = 1'b0;
                end
            end
            SCAN: begin
                gnd_hit_d = gnd_hit_q | gnd_now;
                lft_hit_d = lft_hit_q | lft_now;
                rgt_hit_d = rgt_hit_q | rgt_now;
                if (frame_end) state_d = PUBLISH;
            end
            PUBLISH: begin
                // Fresh data beats a coincident ack.
                gnd_out_d = gnd_hit_q;
                lft_out_d = lft_hit_q;
                rgt_out_d = rgt_hit_q;
                fv_d      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            vo_dly_q  <= '0;
            px_q      <= '0;
            py_q      <= '0;
            gnd_hit_q <= 1'b0;
            lft_hit_q <= 1'b0;
            rgt_hit_q <= 1'b0;
            gnd_out_q <= 1'b0;
            lft_out_q <= 1'b0;
            rgt_out_q <= 1'b0;
            fv_q      <= 1'b0;
            for (int i = 0; i < PIPE_DLY; i++) begin
                x_dly_q[i] <= '0;
                y_dly_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            vo_dly_q  <= vo_dly_d;
            px_q      <= px_d;
            py_q      <= py_d;
            gnd_hit_q <= gnd_hit_d;
            lft_hit_q <= lft_hit_d;
            rgt_hit_q <= rgt_hit_d;
            gnd_out_q <= gnd_out_d;
            lft_out_q <= lft_out_d;
            rgt_out_q <= rgt_out_d;
            fv_q      <= fv_d;
            for (int i = 0; i < PIPE_DLY; i++) begin
                x_dly_q[i] <= x_dly_d[i];
                y_dly_q[i] <= y_dly_d[i];
            end
        end
    end

    assign on_ground   = gnd_out_q;
    assign wall_left   = lft_out_q;
    assign wall_right  = rgt_out_q;
    assign flags_valid = fv_q;

endmodule

// File: tb/tb_platform_probe.sv
// Directed bench for platform_probe: sparse pixel streams, hand-computed flags.
// Expects PIPE_DLY=1 (default); ceiling expectation follows CEIL_PROBE_EN.
module tb_platform_probe;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [9:0] x, y;
    logic       platforms_on;
    logic [9:0] player_x, player_y;
    logic       on_ground, wall_left, wall_right, ceiling;
    logic       flags_valid;
    logic       flags_ack;

    logic pl_pend;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef CEIL_PROBE_EN
    localparam logic CEIL_EXP = 1'b1;
`else
    localparam logic CEIL_EXP = 1'b0;
`endif

    platform_probe dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .x            (x),
        .y            (y),
        .platforms_on (platforms_on),
        .player_x     (player_x),
        .player_y     (player_y),
        .on_ground    (on_ground),
        .wall_left    (wall_left),
        .wall_right   (wall_right),
        .ceiling      (ceiling),
        .flags_valid  (flags_valid),
        .flags_ack    (flags_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present one pixel; its platform flag arrives one cycle later.
    task automatic pix(input int xx, input int yy,
                       input logic vo, input logic pl);
        x            = 10'(xx);
        y            = 10'(yy);
        video_on     = vo;
        platforms_on = pl_pend;
        pl_pend      = pl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pix(5, 5, 1'b0, 1'b0);
    endtask

    task automatic start_frame(input int pxx, input int pyy);
        player_x = 10'(pxx);
        player_y = 10'(pyy);
        pix(0, 0, 1'b1, 1'b0);
    endtask

    // Last pixel, the PUBLISH cycle (optional ack), then outputs are loaded.
    task automatic finish_frame(input logic ack_on_pub);
        pix(639, 479, 1'b1, 1'b0);
        idle();
        flags_ack = ack_on_pub;
        idle();
        flags_ack = 1'b0;
    endtask

    task automatic ack();
        flags_ack = 1'b1;
        idle();
        flags_ack = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        video_on     = 1'b0;
        x            = '0;
        y            = '0;
        platforms_on = 1'b0;
        player_x     = '0;
        player_y     = '0;
        flags_ack    = 1'b0;
        pl_pend      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ground", on_ground, 1'b0);
        chk("rst_left", wall_left, 1'b0);
        chk("rst_right", wall_right, 1'b0);
        chk("rst_ceil", ceiling, 1'b0);
        chk("rst_valid", flags_valid, 1'b0);

        // Floor strip under the feet, x=102..113.
        start_frame(100, 200);
        for (int i = 100; i <= 115; i++)
            pix(i, 216, 1'b1, (i >= 102 && i <= 113));
        pix(639, 479, 1'b1, 1'b0);
        chk("t1_valid_pre", flags_valid, 1'b0);
        idle();
        chk("t1_valid_pub", flags_valid, 1'b0);
        idle();
        chk("t1_valid", flags_valid, 1'b1);
        chk("t1_ground", on_ground, 1'b1);
        chk("t1_left", wall_left, 1'b0);
        chk("t1_right", wall_right, 1'b0);
        chk("t1_ceil", ceiling, 1'b0);
        ack();
        chk("t1_acked", flags_valid, 1'b0);
        ack();
        chk("t1_ack_idle", flags_valid, 1'b0);

        // Player at left edge: left probe off, right probe at x=16.
        start_frame(0, 300);
        pix(0, 302, 1'b1, 1'b1);
        pix(0, 305, 1'b1, 1'b1);
        pix(16, 302, 1'b1, 1'b1);
        finish_frame(1'b0);
        chk("t2_valid", flags_valid, 1'b1);
        chk("t2_left", wall_left, 1'b0);
        chk("t2_right", wall_right, 1'b1);
        chk("t2_ground", on_ground, 1'b0);

        // Foot row just outside the band; overwrites unacked flags.
        start_frame(100, 200);
        pix(101, 216, 1'b1, 1'b1);
        pix(114, 216, 1'b1, 1'b1);
        finish_frame(1'b0);
        chk("t3_valid", flags_valid, 1'b1);
        chk("t3_ground", on_ground, 1'b0);
        chk("t3_right", wall_right, 1'b0);
        ack();

        // player_x moves mid-frame: latched 100 holds this frame.
        start_frame(100, 200);
        pix(102, 216, 1'b1, 1'b1);
        player_x = 10'd300;
        pix(302, 216, 1'b1, 1'b1);
        finish_frame(1'b0);
        chk("t4_ground_a", on_ground, 1'b1);
        ack();
        start_frame(300, 200);
        pix(102, 216, 1'b1, 1'b1);
        finish_frame(1'b0);
        chk("t4_valid_b", flags_valid, 1'b1);
        chk("t4_ground_b", on_ground, 1'b0);
        ack();

        // Reset mid-frame discards it.
        start_frame(100, 200);
        pix(102, 216, 1'b1, 1'b1);
        reset = 1'b1;
        pix(320, 240, 1'b1, 1'b0);
        reset = 1'b0;
        chk("t5_rst_valid", flags_valid, 1'b0);
        pix(102, 216, 1'b1, 1'b1);
        finish_frame(1'b0);
        idle();
        chk("t5_no_pub", flags_valid, 1'b0);
        start_frame(100, 200);
        pix(102, 216, 1'b1, 1'b1);
        finish_frame(1'b0);
        chk("t5_valid_d", flags_valid, 1'b1);
        chk("t5_ground_d", on_ground, 1'b1);
        start_frame(0, 300);
        pix(16, 302, 1'b1, 1'b1);
        finish_frame(1'b1);
        chk("t5_valid_e", flags_valid, 1'b1);
        chk("t5_right_e", wall_right, 1'b1);
        chk("t5_ground_e", on_ground, 1'b0);
        ack();
        chk("t5_acked", flags_valid, 1'b0);

        // Head row and left wall.
        start_frame(100, 200);
        pix(99, 205, 1'b1, 1'b1);
        pix(105, 199, 1'b1, 1'b1);
        finish_frame(1'b0);
        chk("t6_ceil", ceiling, CEIL_EXP);
        chk("t6_left", wall_left, 1'b1);
        chk("t6_ground", on_ground, 1'b0);
        chk("t6_right", wall_right, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
